// File: rtl/three_input_gate_sweep_ctrl.sv
// Self-test sequencer: walks the three-input gate through all 32 {code,c,b,a} vectors and
// captures o_f into a truth table. Define THREE_INPUT_GATE_SWEEP_CHECK_EN for the pass/fail compare.
module three_input_gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_f,
`ifdef THREE_INPUT_GATE_SWEEP_CHECK_EN
  input  logic [31:0] i_expected,
`endif
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic [1:0]  o_code,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_table
`ifdef THREE_INPUT_GATE_SWEEP_CHECK_EN
  ,
  output logic        o_pass,
  output logic [4:0]  o_err_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [4:0]  idx;
  logic [3:0]  cnt;
  logic        start_sweep;
  logic        do_sample;

  always_comb begin
    next_state  = state;
    start_sweep = 1'b0;
    do_sample   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          next_state  = S_DRIVE;
          start_sweep = 1'b1;
        end
      end
      S_DRIVE: begin
        if (i_abort)              next_state = S_IDLE;
        else if (cnt == CNT_LAST) next_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        // An abort here drops the pending sample so bits >= idx stay clear.
        if (i_abort) begin
          next_state = S_IDLE;
        end else begin
          do_sample  = 1'b1;
          next_state = (idx == 5'd31) ? S_DONE : S_DRIVE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  // idx only advances below 31, so the final vector stays on the gate after DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx     <= '0;
      cnt     <= '0;
      o_table <= '0;
    end else if (start_sweep) begin
      idx     <= '0;
      cnt     <= '0;
      o_table <= '0;
    end else if (do_sample) begin
      o_table[idx] <= i_f;
      cnt          <= '0;
      if (idx != 5'd31) idx <= idx + 5'd1;
    end else if (state == S_DRIVE) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign o_a    = idx[0];
  assign o_b    = idx[1];
  assign o_c    = idx[2];
  assign o_code = idx[4:3];
  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);

`ifdef THREE_INPUT_GATE_SWEEP_CHECK_EN
  logic [31:0] mismatch;
  logic [4:0]  first_err;

  // Descending scan leaves the lowest mismatching bit position in first_err.
  always_comb begin
    mismatch  = o_table ^ i_expected;
    first_err = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mismatch[i]) first_err = 5'(i);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pass    <= 1'b0;
      o_err_idx <= '0;
    end else if (start_sweep) begin
      o_pass    <= 1'b0;
      o_err_idx <= '0;
    end else if (state == S_DONE) begin
      o_pass    <= (mismatch == 32'd0);
      o_err_idx <= first_err;
    end
  end
`endif

endmodule

// File: tb/tb_three_input_gate_sweep_ctrl.sv
// Randomised self-checking bench: a behavioural gate model answers the sweep and a
// truth-table model gives the expected capture, latency and handshake behaviour.
module tb_three_input_gate_sweep_ctrl;

  localparam int LAT = 32 * (2 + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        f_in;
  logic        a, b, c;
  logic [1:0]  code;
  logic        busy, done;
  logic [31:0] tbl;
  logic [31:0] expected;
  logic        pass;
  logic [4:0]  err_idx;

  int          checks = 0;
  int          errors = 0;
  int          mode;
  logic [31:0] rnd_tbl;
  logic [4:0]  vec;

  three_input_gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_f        (f_in),
`ifdef THREE_INPUT_GATE_SWEEP_CHECK_EN
    .i_expected (expected),
`endif
    .o_a        (a),
    .o_b        (b),
    .o_c        (c),
    .o_code     (code),
    .o_busy     (busy),
    .o_done     (done),
    .o_table    (tbl)
`ifdef THREE_INPUT_GATE_SWEEP_CHECK_EN
    ,
    .o_pass     (pass),
    .o_err_idx  (err_idx)
`endif
  );

`ifndef THREE_INPUT_GATE_SWEEP_CHECK_EN
  assign pass    = 1'b0;
  assign err_idx = '0;
`endif

  always #5 clk = ~clk;

  // Gate model: 0 f=a, 1 f=code[1], 2 f=1, otherwise an arbitrary random truth table.
  always_comb begin
    vec = {code, c, b, a};
    case (mode)
      0:       f_in = vec[0];
      1:       f_in = vec[4];
      2:       f_in = 1'b1;
      default: f_in = rnd_tbl[vec];
    endcase
  end

  function automatic logic [31:0] model_table(input int m, input logic [31:0] r);
    logic [31:0] t;
    t = '0;
    for (int k = 0; k < 32; k++) begin
      case (m)
        0:       t[k] = (k % 2) == 1;
        1:       t[k] = k >= 16;
        2:       t[k] = 1'b1;
        default: t[k] = r[k];
      endcase
    end
    return t;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep and follows it until the block is idle again. lat = cycles from the
  // start edge to the first done, end_j = cycle at which busy was seen low.
  task automatic apply_stimulus(input int second_start_at, input int abort_after,
                                input bit track, output int lat, output int dones,
                                output int end_j);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("busy_after_start", 32'(busy), 32'd1);
    lat   = 0;
    dones = 0;
    end_j = 0;
    for (int j = 1; j <= 200; j++) begin
      if (track && (j - 1) <= LAT - 1)
        check_output("vector_on_gate", 32'(vec), 32'((j - 1) / 3));
      if (abort_after > 0 && (j - 1) == 3 * abort_after) abort = 1'b1;
      if (second_start_at > 0 && (j - 1) == second_start_at) start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        dones++;
        if (lat == 0) lat = j;
      end
      if (!busy && !done) begin
        end_j = j;
        break;
      end
    end
    if (end_j == 0) check_output("sweep_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat, dones, end_j, v, bitpos, bitpos2, lowest;
    logic [31:0] m;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    rnd_tbl = '0; expected = '0;
    #12;
    check_output("reset_table", tbl, 32'd0);
    check_output("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check_output("reset_vector", 32'(vec), 32'd0);
    rst = 1'b0;
    step();

    mode = 0;
    apply_stimulus(0, 0, 1'b0, lat, dones, end_j);
    check_output("t1_latency", 32'(lat), 32'(LAT));
    check_output("t1_done_count", 32'(dones), 32'd1);
    check_output("t1_busy_low_after_done", 32'(end_j), 32'(lat + 1));
    check_output("t1_table", tbl, 32'hAAAA_AAAA);
    check_output("t1_last_vector_held", 32'(vec), 32'd31);

    mode = 1;
    apply_stimulus(0, 0, 1'b1, lat, dones, end_j);
    check_output("t2_table", tbl, 32'hFFFF_0000);
    check_output("t2_latency", 32'(lat), 32'(LAT));

    mode = 2;
    apply_stimulus(0, 10, 1'b0, lat, dones, end_j);
    check_output("t3_no_done", 32'(dones), 32'd0);
    check_output("t3_partial_table", tbl, 32'h0000_03FF);
    check_output("t3_idle", 32'(busy), 32'd0);
    mode = 3;
    rnd_tbl = $urandom();
    apply_stimulus(0, 0, 1'b0, lat, dones, end_j);
    check_output("t3_restart_table", tbl, model_table(3, rnd_tbl));
    check_output("t3_restart_done", 32'(dones), 32'd1);

    for (int r = 0; r < 3; r++) begin
      rnd_tbl = $urandom();
      v = $urandom_range(1, 31);
      m = (32'h1 << v) - 32'h1;
      apply_stimulus(0, v, 1'b0, lat, dones, end_j);
      check_output("rand_abort_table", tbl, model_table(3, rnd_tbl) & m);
      check_output("rand_abort_no_done", 32'(dones), 32'd0);
    end

    rnd_tbl = $urandom();
    apply_stimulus(5, 0, 1'b0, lat, dones, end_j);
    check_output("t4_latency", 32'(lat), 32'(LAT));
    check_output("t4_done_count", 32'(dones), 32'd1);
    check_output("t4_table", tbl, model_table(3, rnd_tbl));

    mode = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    #1 rst = 1'b1;
    #1;
    check_output("t5_async_table", tbl, 32'd0);
    check_output("t5_async_ctrl", {27'd0, busy, done, vec[2:0]}, 32'd0);
    check_output("t5_async_code", 32'(code), 32'd0);
    #2 rst = 1'b0;
    dones = 0;
    repeat (100) begin
      step();
      if (done) dones++;
    end
    check_output("t5_no_done_after_reset", 32'(dones), 32'd0);
    mode = 3;
    rnd_tbl = $urandom();
    apply_stimulus(0, 0, 1'b0, lat, dones, end_j);
    check_output("t5_full_table", tbl, model_table(3, rnd_tbl));

`ifdef THREE_INPUT_GATE_SWEEP_CHECK_EN
    mode = 0;
    expected = 32'hAAAA_AAAA;
    apply_stimulus(0, 0, 1'b0, lat, dones, end_j);
    check_output("t6_pass", 32'(pass), 32'd1);
    check_output("t6_err_idx_clean", 32'(err_idx), 32'd0);
    expected = 32'hAAAA_AAAA ^ 32'h80;
    apply_stimulus(0, 0, 1'b0, lat, dones, end_j);
    check_output("t6_fail_pass", 32'(pass), 32'd0);
    check_output("t6_err_idx", 32'(err_idx), 32'd7);
    mode = 3;
    rnd_tbl = $urandom();
    bitpos  = $urandom_range(0, 31);
    bitpos2 = $urandom_range(0, 31);
    lowest  = (bitpos < bitpos2) ? bitpos : bitpos2;
    expected = rnd_tbl ^ (32'h1 << bitpos) ^ (32'h1 << bitpos2);
    if (bitpos == bitpos2) expected = rnd_tbl ^ (32'h1 << bitpos);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("t6_pass_cleared_at_start", {26'd0, pass, err_idx}, 32'd0);
    for (int j = 0; j < 200 && !done; j++) step();
    step();
    check_output("t6_rand_pass", 32'(pass), 32'd0);
    check_output("t6_rand_err_idx", 32'(err_idx), 32'(lowest));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
